// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
// Shared definitions for the exhaustive gate-sweep controller:
//   - sweep_state_t : controller FSM encoding (IDLE=0, WAIT=1, CHECK=2, DONE=3)
//   - TT_*          : expected truth tables; bit i is the expected y for stim==i
//   - tt_width()    : truth-table width for a given number of gate inputs
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;
    localparam logic [7:0] TT_XOR3 = 8'h96;

    // One expected-output bit per input vector.
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage : gate_sweep_pkg

// File: rtl/gate_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl_if
// Bundles the sweep handshake, the stimulus/return path to the gate DUT and
// the result bus of gate_sweep_ctrl.
//   start           : request a sweep (bench -> controller)
//   stim            : input vector for the gate DUT (controller -> DUT)
//   dut_y           : gate DUT output, combinational return (DUT -> controller)
//   busy/done/pass  : sweep status
//   err_cnt         : mismatching vectors in the last sweep (N_IN+1 bits)
//   first_err_vec   : stim value of the first mismatch
//   first_err_valid : first_err_vec holds a captured value
// Modports: master = bench/DUT side, slave = controller side.
// -----------------------------------------------------------------------------
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    modport master (
        output start,
        output dut_y,
        input  stim,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  first_err_vec,
        input  first_err_valid
    );

    modport slave (
        input  start,
        input  dut_y,
        output stim,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output first_err_vec,
        output first_err_valid
    );

endinterface : gate_sweep_ctrl_if

// File: rtl/gate_sweep_settle_timer.sv
// -----------------------------------------------------------------------------
// gate_sweep_settle_timer
// Loadable down-counter that times the settle interval of each vector.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value loaded on i_load
//   i_dec       : decrement by one
//   o_zero      : count is zero
// -----------------------------------------------------------------------------
module gate_sweep_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : gate_sweep_settle_timer

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Synthesizable exhaustive-sweep checker for small combinational gates.
// Drives stim = 0 .. 2^N_IN-1, holds each vector SETTLE cycles, then checks
// dut_y against EXP_TT[stim] in a dedicated CHECK cycle, so every vector
// takes SETTLE+1 cycles. Results are held until the next accepted start.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : gate_sweep_ctrl_if.slave (start, stim, dut_y, busy, done, pass,
//          err_cnt, first_err_vec, first_err_valid)
// Parameters:
//   N_IN   : number of gate inputs (1..4)
//   SETTLE : hold cycles before each check (>= 1)
//   EXP_TT : expected truth table, 2^N_IN bits
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0] EXP_TT = TT_AND2
) (
    input  logic              clk,
    input  logic              rst,
    gate_sweep_ctrl_if.slave  bus
);

    localparam int              CW       = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]   LOAD_VAL = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    sweep_state_t    r_state;
    logic [N_IN-1:0] r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err_cnt;
    logic [N_IN-1:0] r_first_err_vec;
    logic            r_first_err_valid;

    logic w_tmr_zero;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_exp_y;
    logic w_mismatch;
    logic w_last_vec;

    assign w_exp_y    = EXP_TT[r_stim];
    assign w_mismatch = (bus.dut_y != w_exp_y);
    assign w_last_vec = (r_stim == LAST_VEC);

    // The timer is reloaded whenever a vector's hold interval begins: on an
    // accepted start and on every non-terminal CHECK.
    assign w_tmr_load = ((r_state == IDLE) && bus.start) ||
                        ((r_state == CHECK) && !w_last_vec);
    assign w_tmr_dec  = (r_state == WAIT) && !w_tmr_zero;

    gate_sweep_settle_timer #(
        .W (CW)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_stim            <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_stim            <= '0;
                        r_err_cnt         <= '0;
                        r_first_err_vec   <= '0;
                        r_first_err_valid <= 1'b0;
                        r_pass            <= 1'b0;
                        r_busy            <= 1'b1;
                        r_state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_tmr_zero) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                        if (!r_first_err_valid) begin
                            r_first_err_vec   <= r_stim;
                            r_first_err_valid <= 1'b1;
                        end
                    end
                    if (w_last_vec) begin
                        // Fold the final CHECK into pass, since r_err_cnt
                        // is only updated at this same edge.
                        r_pass  <= !w_mismatch && (r_err_cnt == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_stim  <= r_stim + 1'b1;
                        r_state <= WAIT;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stim            = r_stim;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_cnt         = r_err_cnt;
    assign bus.first_err_vec   = r_first_err_vec;
    assign bus.first_err_valid = r_first_err_valid;

endmodule : gate_sweep_ctrl
